box_motion: RTL and testbench

//  Per-frame position engine for the bouncing-box screensaver image.
//  - Sits upstream of the box pixel renderer.
//  - Watches VGA vsync and advances the box's top-left corner once per frame.
//  - Reflects the box off the visible-area edges.
//  - Commits the new position atomically, so the renderer never sees a torn
//    X/Y pair within a frame.

---
 rtl/screensaver_pkg.sv | 31 +++
 rtl/box_axis_reflect.sv | 59 +++++
 rtl/box_motion.sv | 147 ++++++++++++++
 tb/tb_box_motion.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/screensaver_pkg.sv
// ----------------------------------------------------------------------------
// screensaver_pkg
//  Shared types and constants for the bouncing-box screensaver image.
//  - VGA 640x480 visible-area dimensions.
//  - coord_t  : 10-bit screen coordinate.
//  - rgb444_t : 12-bit {r,g,b} colour, 4 bits per channel.
//  - PALETTE  : 8-entry colour ROM stepped on every bounce when the
//               BOX_COLOR_CYCLE_EN build macro is defined.
//  - state_t  : position-engine FSM states.
// ----------------------------------------------------------------------------
package screensaver_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef logic [9:0]  coord_t;
    typedef logic [11:0] rgb444_t;

    localparam int PAL_N = 8;
    localparam rgb444_t PALETTE [PAL_N] = '{
        12'hFFF, 12'hF00, 12'h0F0, 12'h00F,
        12'hFF0, 12'h0FF, 12'hF0F, 12'hF80
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/box_axis_reflect.sv
// ----------------------------------------------------------------------------
// box_axis_reflect
//  Combinational next-position / direction / reflect for one axis.
//  Moving forward the position clamps at MAX, moving backward at 0; landing
//  exactly on a wall counts as a reflection and flips the direction.
//  Ports:
//   pos_i      in   current position
//   dir_i      in   1 = increasing, 0 = decreasing
//   pos_o      out  next position
//   dir_o      out  next direction
//   reflect_o  out  1 when this step hit a wall
// ----------------------------------------------------------------------------
module box_axis_reflect
    import screensaver_pkg::*;
#(
    parameter int MAX  = 576,
    parameter int STEP = 2
) (
    input  coord_t pos_i,
    input  logic   dir_i,
    output coord_t pos_o,
    output logic   dir_o,
    output logic   reflect_o
);

    // 11-bit arithmetic: pos + STEP can never wrap.
    localparam logic [10:0] MAX_W  = 11'(MAX);
    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [10:0] pos_w;
    logic [10:0] sum;

    assign pos_w = {1'b0, pos_i};
    assign sum   = pos_w + STEP_W;

    always_comb begin
        pos_o     = pos_i;
        dir_o     = dir_i;
        reflect_o = 1'b0;
        if (dir_i) begin
            if (sum >= MAX_W) begin
                pos_o     = MAX_W[9:0];
                dir_o     = 1'b0;
                reflect_o = 1'b1;
            end else begin
                pos_o = sum[9:0];
            end
        end else begin
            if (pos_w <= STEP_W) begin
                pos_o     = '0;
                dir_o     = 1'b1;
                reflect_o = 1'b1;
            end else begin
                pos_o = 10'(pos_w - STEP_W);
            end
        end
    end

endmodule

// File: rtl/box_motion.sv
// ----------------------------------------------------------------------------
// box_motion
//  Per-frame position engine for the bouncing-box screensaver. Each vsync
//  falling edge (unless paused) computes the next corner position into
//  shadow registers, then commits X/Y together so the renderer never sees a
//  torn pair.
//  Build macro: BOX_COLOR_CYCLE_EN - step box_rgb through PALETTE on every
//  bouncing commit; otherwise box_rgb is constant white.
//  Ports:
//   clk_25_175  in   pixel clock
//   rst         in   synchronous active-high reset
//   vsync       in   VGA vsync, active low
//   pause       in   1 = hold position and direction
//   box_x/y     out  committed box top-left corner
//   dir_x/y     out  1 = moving right / down
//   bounce      out  commit pulse, either axis reflected
//   corner_hit  out  commit pulse, both axes reflected
//   box_rgb     out  box colour {r,g,b}
// ----------------------------------------------------------------------------
module box_motion
    import screensaver_pkg::*;
#(
    parameter int BOX_W  = 64,
    parameter int BOX_H  = 48,
    parameter int STEP_X = 2,
    parameter int STEP_Y = 2,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 0
) (
    input  logic    clk_25_175,
    input  logic    rst,
    input  logic    vsync,
    input  logic    pause,
    output coord_t  box_x,
    output coord_t  box_y,
    output logic    dir_x,
    output logic    dir_y,
    output logic    bounce,
    output logic    corner_hit,
    output rgb444_t box_rgb
);

    state_t state_q, state_d;
    logic   vsync_q;
    logic   tick;
    logic   load_shadow, commit;

    coord_t x_q, y_q;
    logic   dx_q, dy_q;
    coord_t sh_x_q, sh_y_q;
    logic   sh_dx_q, sh_dy_q, sh_rx_q, sh_ry_q;

    coord_t nx, ny;
    logic   ndx, ndy, rx, ry;

    assign tick = vsync_q & ~vsync;

    box_axis_reflect #(.MAX(H_VISIBLE - BOX_W), .STEP(STEP_X)) u_axis_x (
        .pos_i(x_q), .dir_i(dx_q), .pos_o(nx), .dir_o(ndx), .reflect_o(rx)
    );

    box_axis_reflect #(.MAX(V_VISIBLE - BOX_H), .STEP(STEP_Y)) u_axis_y (
        .pos_i(y_q), .dir_i(dy_q), .pos_o(ny), .dir_o(ndy), .reflect_o(ry)
    );

    always_ff @(posedge clk_25_175) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Ticks seen outside IDLE are dropped; they cannot occur at legal timing.
    always_comb begin
        state_d     = state_q;
        load_shadow = 1'b0;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE:   if (tick && !pause) state_d = ST_CALC;
            ST_CALC: begin
                load_shadow = 1'b1;
                state_d     = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25_175) begin
        if (rst) begin
            vsync_q <= 1'b1;
            x_q     <= coord_t'(X_INIT);
            y_q     <= coord_t'(Y_INIT);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            sh_dx_q <= 1'b0;
            sh_dy_q <= 1'b0;
            sh_rx_q <= 1'b0;
            sh_ry_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (load_shadow) begin
                sh_x_q  <= nx;
                sh_y_q  <= ny;
                sh_dx_q <= ndx;
                sh_dy_q <= ndy;
                sh_rx_q <= rx;
                sh_ry_q <= ry;
            end
            if (commit) begin
                x_q  <= sh_x_q;
                y_q  <= sh_y_q;
                dx_q <= sh_dx_q;
                dy_q <= sh_dy_q;
            end
        end
    end

    // During COMMIT the outputs are taken straight from the shadow so the new
    // position is visible two cycles after the tick; the committed registers
    // take over from the next cycle with identical values.
    assign box_x      = commit ? sh_x_q  : x_q;
    assign box_y      = commit ? sh_y_q  : y_q;
    assign dir_x      = commit ? sh_dx_q : dx_q;
    assign dir_y      = commit ? sh_dy_q : dy_q;
    assign bounce     = commit & (sh_rx_q | sh_ry_q);
    assign corner_hit = commit & sh_rx_q & sh_ry_q;

`ifdef BOX_COLOR_CYCLE_EN
    logic [2:0] pal_q, pal_nxt, pal_sel;

    assign pal_nxt = pal_q + 3'd1;
    assign pal_sel = bounce ? pal_nxt : pal_q;
    assign box_rgb = PALETTE[pal_sel];

    always_ff @(posedge clk_25_175) begin
        if (rst)         pal_q <= '0;
        else if (bounce) pal_q <= pal_nxt;
    end
`else
    assign box_rgb = 12'hFFF;
`endif

endmodule

// File: tb/tb_box_motion.sv
module tb_box_motion;
    import screensaver_pkg::*;

    localparam int N = 3;
    localparam int XI [N] = '{0, 574, 576};
    localparam int YI [N] = '{0, 0, 432};
    localparam int LIM_X = 640 - 64;
    localparam int LIM_Y = 480 - 48;

    logic clk_25_175 = 1'b0;
    logic rst, vsync, pause;

    coord_t  bx [N];
    coord_t  by [N];
    logic    dxo [N];
    logic    dyo [N];
    logic    bo [N];
    logic    co [N];
    rgb444_t rgb [N];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int mx [N];
    int my [N];
    bit mdx [N];
    bit mdy [N];
    bit mb [N];
    bit mc [N];
    int mpal [N];

    always #20 clk_25_175 = ~clk_25_175;

    for (genvar g = 0; g < N; g++) begin : g_dut
        box_motion #(.X_INIT(XI[g]), .Y_INIT(YI[g])) u_dut (
            .clk_25_175 (clk_25_175),
            .rst        (rst),
            .vsync      (vsync),
            .pause      (pause),
            .box_x      (bx[g]),
            .box_y      (by[g]),
            .dir_x      (dxo[g]),
            .dir_y      (dyo[g]),
            .bounce     (bo[g]),
            .corner_hit (co[g]),
            .box_rgb    (rgb[g])
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns {reflect, dir, pos[9:0]}: move by step, clamp to [0, lim].
    function automatic logic [11:0] axis_step(int p, bit d, int lim, int step);
        int t;
        t = d ? p + step : p - step;
        if (d && t >= lim)  return {1'b1, 1'b0, 10'(lim)};
        if (!d && t <= 0)   return {1'b1, 1'b1, 10'd0};
        return {1'b0, d, 10'(t)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = XI[i]; my[i] = YI[i];
            mdx[i] = 1'b1; mdy[i] = 1'b1;
            mb[i] = 1'b0;  mc[i] = 1'b0;
            mpal[i] = 0;
        end
    endtask

    task automatic model_frame(input bit paused);
        logic [11:0] rx, ry;
        for (int i = 0; i < N; i++) begin
            if (paused) begin
                mb[i] = 1'b0; mc[i] = 1'b0;
            end else begin
                rx = axis_step(mx[i], mdx[i], LIM_X, 2);
                ry = axis_step(my[i], mdy[i], LIM_Y, 2);
                mx[i] = int'(rx[9:0]); mdx[i] = rx[10];
                my[i] = int'(ry[9:0]); mdy[i] = ry[10];
                mb[i] = rx[11] | ry[11];
                mc[i] = rx[11] & ry[11];
                if (mb[i]) mpal[i] = (mpal[i] + 1) % 8;
            end
        end
    endtask

    task automatic check_all(input string ph, input bit pulse);
        int exp_rgb;
        for (int i = 0; i < N; i++) begin
`ifdef BOX_COLOR_CYCLE_EN
            exp_rgb = int'(PALETTE[mpal[i]]);
`else
            exp_rgb = 12'hFFF;
`endif
            chk($sformatf("%s[%0d].box_x", ph, i), int'(bx[i]), mx[i]);
            chk($sformatf("%s[%0d].box_y", ph, i), int'(by[i]), my[i]);
            chk($sformatf("%s[%0d].dir_x", ph, i), int'(dxo[i]), int'(mdx[i]));
            chk($sformatf("%s[%0d].dir_y", ph, i), int'(dyo[i]), int'(mdy[i]));
            chk($sformatf("%s[%0d].bounce", ph, i), int'(bo[i]), pulse ? int'(mb[i]) : 0);
            chk($sformatf("%s[%0d].corner", ph, i), int'(co[i]), pulse ? int'(mc[i]) : 0);
            chk($sformatf("%s[%0d].rgb", ph, i), int'(rgb[i]), exp_rgb);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic frame(input bit p);
        vsync = 1'b0;
        pause = p;
        @(negedge clk_25_175); check_all("tick", 0);
        @(posedge clk_25_175); #1;
        pause = 1'($urandom_range(0, 1));   // mid-update pause must not abort
        @(negedge clk_25_175); check_all("calc", 0);
        model_frame(p);
        @(negedge clk_25_175); check_all("commit", 1);
        @(posedge clk_25_175); #1;
        vsync = 1'b1;
        @(negedge clk_25_175); check_all("after", 0);
        repeat ($urandom_range(3, 8)) @(posedge clk_25_175);
        #1;
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; pause = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_25_175);
        #1;
        @(negedge clk_25_175); check_all("reset", 0);
        @(posedge clk_25_175); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk_25_175);
        #1;
        @(negedge clk_25_175); check_all("idle", 0);
        @(posedge clk_25_175); #1;

        for (int f = 0; f < 5; f++) frame(1'b0);
        chk("five.box_x", int'(bx[0]), 10);
        chk("five.box_y", int'(by[0]), 10);
        chk("five.wall_x", int'(bx[1]), 568);

        for (int f = 0; f < 3; f++) frame(1'b1);
        chk("paused.box_x", int'(bx[0]), 10);
        frame(1'b0);
        chk("resume.box_x", int'(bx[0]), 12);

        for (int f = 0; f < 30; f++) frame($urandom_range(0, 3) == 0);

        // reset on the cycle after a tick: update dropped, no pulse
        vsync = 1'b0; pause = 1'b0;
        @(posedge clk_25_175); #1;
        rst = 1'b1; vsync = 1'b1;
        @(posedge clk_25_175); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk_25_175); check_all("rstmid", 1);
        @(negedge clk_25_175); check_all("rstmid2", 1);
        repeat (4) @(posedge clk_25_175);
        #1;

        for (int f = 0; f < 6; f++) frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
